// File: rtl/align_mantissas.sv
// Aligns the smaller-exponent significand and adds/subtracts it. Latency k+2 edges, k=min(diff,14).
// One transaction in flight: in_ready only in IDLE, result held in DONE until out_ready. Option: ALIGN_GRS_EN.
module align_mantissas (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sub,
  input  logic [4:0]  in_diff,
  input  logic [4:0]  in_exp,
  input  logic [10:0] in_siga,
  input  logic [10:0] in_sigb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_sum,
  output logic        out_neg,
  output logic [4:0]  out_exp,
  output logic [2:0]  out_grs
);

`ifdef ALIGN_GRS_EN
  localparam int EXT = 3;
`else
  localparam int EXT = 0;
`endif
  localparam int BW = 11 + EXT;
  localparam int RW = 12 + EXT;

  typedef enum logic [1:0] {IDLE, SHIFT, ADD, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      k_q, k_d;
  logic            sub_q, sub_d;
  logic [4:0]      exp_q, exp_d;
  logic [10:0]     a_q, a_d;
  logic [BW-1:0]   b_q, b_d;
  logic [11:0]     sum_q, sum_d;
  logic            neg_q, neg_d;
  logic [4:0]      oexp_q, oexp_d;
  logic [2:0]      grs_q, grs_d;

  logic [3:0]      k_load;
  logic [BW-1:0]   b_shr;
  logic [RW-1:0]   a_ext, b_ext, raw, mag;
  logic            lt;
  logic [11:0]     sum_n;
  logic [2:0]      grs_n;

  assign k_load = (in_diff > 5'd14) ? 4'd14 : in_diff[3:0];

`ifdef ALIGN_GRS_EN
  // Bit 0 is the sticky position: anything shifted past it is ORed in, never lost.
  assign b_shr = {1'b0, b_q[BW-1:2], b_q[1] | b_q[0]};
`else
  assign b_shr = b_q >> 1;
`endif

  assign a_ext = RW'(a_q) << EXT;
  assign b_ext = RW'(b_q);
  assign lt    = a_ext < b_ext;
  assign raw   = sub_q ? (a_ext - b_ext) : (a_ext + b_ext);
  assign mag   = (sub_q && lt) ? (b_ext - a_ext) : raw;

`ifdef ALIGN_GRS_EN
  assign sum_n = mag[RW-1:3];
  assign grs_n = mag[2:0];
`else
  assign sum_n = mag;
  assign grs_n = 3'b000;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_neg   = neg_q;
  assign out_exp   = oexp_q;
  assign out_grs   = grs_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    sub_d   = sub_q;
    exp_d   = exp_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    neg_d   = neg_q;
    oexp_d  = oexp_q;
    grs_d   = grs_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sub_d   = in_sub;
          exp_d   = in_exp;
          a_d     = in_siga;
          b_d     = BW'(in_sigb) << EXT;
          k_d     = k_load;
          state_d = (k_load == 4'd0) ? ADD : SHIFT;
        end
      end
      SHIFT: begin
        b_d = b_shr;
        k_d = k_q - 4'd1;
        if (k_q == 4'd1) state_d = ADD;
      end
      ADD: begin
        sum_d   = sum_n;
        neg_d   = sub_q && lt;
        oexp_d  = exp_q;
        grs_d   = grs_n;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      sub_q   <= 1'b0;
      exp_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      neg_q   <= 1'b0;
      oexp_q  <= '0;
      grs_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      sub_q   <= sub_d;
      exp_q   <= exp_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      neg_q   <= neg_d;
      oexp_q  <= oexp_d;
      grs_q   <= grs_d;
    end
  end

endmodule

// File: tb/tb_align_mantissas.sv
// Bench for align_mantissas: directed vector table, backpressure and reset corner cases, random vs model.
module tb_align_mantissas;

`ifdef ALIGN_GRS_EN
  localparam bit GRS = 1'b1;
`else
  localparam bit GRS = 1'b0;
`endif

  logic        clk, rst_n, in_valid, in_ready, in_sub, out_valid, out_ready, out_neg;
  logic [4:0]  in_diff, in_exp, out_exp;
  logic [10:0] in_siga, in_sigb;
  logic [11:0] out_sum;
  logic [2:0]  out_grs;

  align_mantissas dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
    .in_diff(in_diff), .in_exp(in_exp), .in_siga(in_siga), .in_sigb(in_sigb),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_neg(out_neg),
    .out_exp(out_exp), .out_grs(out_grs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  typedef struct packed {
    logic [11:0] sum;
    logic        neg;
    logic [2:0]  grs;
  } res_t;

  typedef struct {
    bit        sub;
    bit [4:0]  diff;
    bit [4:0]  exp;
    bit [10:0] a;
    bit [10:0] b;
    bit [11:0] sum;
    bit        neg;
    bit [2:0]  grs;
    int        lat;
  } vec_t;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Exact arithmetic on scaled integers; shifted-out bits fold into the lowest kept bit.
  function automatic res_t model(input bit sub, input bit [4:0] diff, input bit [10:0] a, input bit [10:0] b);
    res_t r;
    int k, av, bv, full, s;
    k = (diff > 5'd14) ? 14 : int'(diff);
    if (GRS) begin
      av   = int'(a) * 8;
      full = int'(b) * 8;
      bv   = (full >> k) | (((full & ((1 << k) - 1)) != 0) ? 1 : 0);
    end else begin
      av = int'(a);
      bv = int'(b) >> k;
    end
    s = sub ? (av - bv) : (av + bv);
    r.neg = (s < 0);
    if (s < 0) s = -s;
    if (GRS) begin
      r.sum = 12'(s >> 3);
      r.grs = 3'(s & 7);
    end else begin
      r.sum = 12'(s);
      r.grs = 3'b000;
    end
    return r;
  endfunction

  task automatic run_txn(input bit sub, input bit [4:0] diff, input bit [4:0] exp,
                         input bit [10:0] a, input bit [10:0] b, input int hold,
                         output bit [11:0] sum, output bit neg, output bit [4:0] oexp,
                         output bit [2:0] grs, output int lat);
    int w;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("in_ready idle", int'(in_ready), 1);
    in_sub = sub; in_diff = diff; in_exp = exp; in_siga = a; in_sigb = b;
    in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    sum = out_sum; neg = out_neg; oexp = out_exp; grs = out_grs;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic txn_and_check(input string tag, input bit sub, input bit [4:0] diff, input bit [4:0] exp,
                               input bit [10:0] a, input bit [10:0] b, input int hold);
    bit [11:0] s; bit n; bit [4:0] e; bit [2:0] g; int lat;
    res_t m;
    m = model(sub, diff, a, b);
    run_txn(sub, diff, exp, a, b, hold, s, n, e, g, lat);
    check({tag, " sum"}, int'(s), int'(m.sum));
    check({tag, " neg"}, int'(n), int'(m.neg));
    check({tag, " exp"}, int'(e), int'(exp));
    check({tag, " grs"}, int'(g), int'(m.grs));
    check({tag, " lat"}, lat, ((diff > 5'd14) ? 14 : int'(diff)) + 2);
  endtask

  vec_t vecs[10];

  initial begin
    bit [11:0] s; bit n; bit [4:0] e; bit [2:0] g; int lat;
    int w;
    res_t m;

    vecs[0] = '{0, 5'd0,  5'h0F, 11'h400, 11'h400, 12'h800, 0, 3'd0, 2};
    vecs[1] = '{0, 5'd3,  5'h11, 11'h400, 11'h7FF, 12'h4FF, 0, GRS ? 3'd7 : 3'd0, 5};
    vecs[2] = '{1, 5'd0,  5'h12, 11'h400, 11'h600, 12'h200, 1, 3'd0, 2};
    vecs[3] = '{0, 5'd20, 5'h13, 11'h400, 11'h401, 12'h400, 0, GRS ? 3'd1 : 3'd0, 16};
    vecs[4] = '{1, 5'd0,  5'h14, 11'h555, 11'h555, 12'h000, 0, 3'd0, 2};
    vecs[5] = '{1, 5'd1,  5'h15, 11'h400, 11'h7FF, GRS ? 12'h000 : 12'h001, 0, GRS ? 3'd4 : 3'd0, 3};
    vecs[6] = '{0, 5'd14, 5'h16, 11'h7FF, 11'h7FF, 12'h7FF, 0, GRS ? 3'd1 : 3'd0, 16};
    vecs[7] = '{0, 5'd13, 5'h17, 11'h400, 11'h7FF, 12'h400, 0, GRS ? 3'd1 : 3'd0, 15};
    vecs[8] = '{0, 5'd0,  5'h1F, 11'h7FF, 11'h7FF, 12'hFFE, 0, 3'd0, 2};
    vecs[9] = '{1, 5'd2,  5'h01, 11'h400, 11'h7FF, GRS ? 12'h200 : 12'h201, 0, GRS ? 3'd2 : 3'd0, 4};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_sub = 1'b0;
    in_diff = '0; in_exp = '0; in_siga = '0; in_sigb = '0;
    repeat (3) @(negedge clk);
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_sum", int'(out_sum), 0);
    check("reset out_neg", int'(out_neg), 0);
    check("reset out_exp", int'(out_exp), 0);
    check("reset out_grs", int'(out_grs), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset in_ready", int'(in_ready), 1);

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].sub, vecs[i].diff, vecs[i].exp, vecs[i].a, vecs[i].b, i % 3, s, n, e, g, lat);
      check($sformatf("vec%0d sum", i), int'(s), int'(vecs[i].sum));
      check($sformatf("vec%0d neg", i), int'(n), int'(vecs[i].neg));
      check($sformatf("vec%0d exp", i), int'(e), int'(vecs[i].exp));
      check($sformatf("vec%0d grs", i), int'(g), int'(vecs[i].grs));
      check($sformatf("vec%0d lat", i), lat, vecs[i].lat);
    end

    // Backpressure: result must hold and competing operands must be refused.
    m = model(1'b0, 5'd2, 11'h400, 11'h7FF);
    @(negedge clk);
    in_sub = 1'b0; in_diff = 5'd2; in_exp = 5'h0A; in_siga = 11'h400; in_sigb = 11'h7FF;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("bp reached done", int'(out_valid), 1);
    in_sub = 1'b1; in_diff = 5'd0; in_exp = 5'h03; in_siga = 11'h7FF; in_sigb = 11'h123;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d valid", c), int'(out_valid), 1);
      check($sformatf("bp%0d in_ready", c), int'(in_ready), 0);
      check($sformatf("bp%0d sum", c), int'(out_sum), int'(m.sum));
      check($sformatf("bp%0d grs", c), int'(out_grs), int'(m.grs));
      check($sformatf("bp%0d exp", c), int'(out_exp), 'h0A);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp after handshake valid", int'(out_valid), 0);
    check("bp after handshake in_ready", int'(in_ready), 1);
    txn_and_check("post-bp", 1'b1, 5'd4, 5'h05, 11'h4A5, 11'h7C3, 0);

    // Reset in the middle of a 10-step shift.
    @(negedge clk);
    in_sub = 1'b0; in_diff = 5'd10; in_exp = 5'h1B; in_siga = 11'h5A5; in_sigb = 11'h7FF;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid-reset out_valid", int'(out_valid), 0);
    check("mid-reset out_sum", int'(out_sum), 0);
    check("mid-reset out_exp", int'(out_exp), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset in_ready", int'(in_ready), 1);
    check("post-reset out_valid", int'(out_valid), 0);
    txn_and_check("post-reset", 1'b0, 5'd10, 5'h1B, 11'h5A5, 11'h7FF, 0);

    for (int r = 0; r < 40; r++) begin
      txn_and_check($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), 11'(11'h400 | 11'($urandom_range(0, 1023))),
                    11'(11'h400 | 11'($urandom_range(0, 1023))), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/align_mantissas.md
ALIGN_MANTISSAS -- requirements
Module: align_mantissas

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, upstream operand pair valid.
REQ-004 SHALL have port in_ready, output, 1, block accepts an operand pair this cycle.
REQ-005 SHALL have port in_sub, input, 1, effective subtraction (operand signs differ).
REQ-006 SHALL have port in_diff, input, 5, unsigned exponent difference, larger minus smaller.
REQ-007 SHALL have port in_exp, input, 5, larger exponent field.
REQ-008 SHALL have port in_siga, input, 11, larger-exponent significand, hidden bit included, uncomplemented.
REQ-009 SHALL have port in_sigb, input, 11, smaller-exponent significand, hidden bit included, uncomplemented.
REQ-010 SHALL have port out_valid, output, 1, result valid.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-012 SHALL have port out_sum, output, 12, result magnitude, bit 11 carry.
REQ-013 SHALL have port out_neg, output, 1, subtraction result was negative and out_sum holds its magnitude.
REQ-014 SHALL have port out_exp, output, 5, in_exp passed through unchanged.
REQ-015 SHALL have port out_grs, output, 3, guard/round/sticky bits below out_sum LSB.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, ADD, DONE; in_ready=1 only in IDLE.
REQ-017 SHALL, in IDLE on in_valid, capture all in_* fields and load shift count k=min(in_diff,14).
REQ-018 SHALL go IDLE->SHIFT when k>0, IDLE->ADD when k=0.
REQ-019 SHALL, in SHIFT, right-shift the B datapath one bit per cycle, decrement k, go to ADD the cycle k reaches 0.
REQ-020 SHALL treat in_diff>=14 as k=14, leaving the B significand field zero; with ALIGN_GRS_EN, all shifted-out ones remain in sticky.
REQ-021 SHALL, in ADD, compute A+B (in_sub=0) or A-B (in_sub=1) at 12 bits (15 with GRS), register the result, go to DONE.
REQ-022 SHALL, when A-B<0, output the two's-complement magnitude and set out_neg=1; otherwise out_neg=0.
REQ-023 SHALL hold out_valid=1 and stable outputs in DONE until out_ready=1, then return to IDLE next edge.
REQ-024 SHALL give latency k+2 edges from acceptance edge to out_valid=1.
REQ-025 SHALL NOT accept new operands until the current result is consumed (one transaction in flight).
REQ-026 SHALL treat an out_valid/out_ready handshake as completing on the edge where both are 1.

Reset
REQ-027 SHALL, on rst_n=0, immediately enter IDLE and clear out_valid, out_sum, out_neg, out_exp, out_grs and the shift counter to 0, regardless of state.
REQ-028 SHALL drop any in-flight transaction on reset; in_ready=1 in the first cycle after rst_n rises.

Configuration
REQ-029 SHALL, with macro ALIGN_GRS_EN defined, extend the B path by 3 bits, capture guard, round and OR-accumulated sticky during SHIFT, include them in the subtraction borrow, and drive out_grs.
REQ-030 SHALL, without ALIGN_GRS_EN, discard shifted-out bits, drive out_grs=3'b000, and otherwise behave identically.

Verification
REQ-031 SHALL cover add, diff=0: siga=0x400, sigb=0x400, in_sub=0 -> out_sum=0x800, out_neg=0, out_valid 2 edges after acceptance.
REQ-032 SHALL cover add, diff=3: siga=0x400, sigb=0x7FF -> out_sum=0x4FF; GRS build out_grs=3'b111; latency 5 edges.
REQ-033 SHALL cover sub, diff=0: siga=0x400, sigb=0x600 -> out_sum=0x200, out_neg=1.
REQ-034 SHALL cover diff=20: siga=0x400, sigb=0x401, in_sub=0 -> out_sum=0x400, k saturates at 14 (latency 16), GRS build out_grs=3'b001.
REQ-035 SHALL cover backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; new in_valid ignored until handshake.
REQ-036 SHALL cover reset mid-SHIFT with diff=10: rst_n pulsed low at shift 4 -> out_valid=0 at once, in_ready=1 after release, next transaction correct.
